// File: rtl/imu_burst_sampler.sv
// imu_burst_sampler: SPI-mode-3 master for an IMU. Waits out sensor boot,
// writes a configuration table, then performs periodic burst reads.
// Ports:
//   clk, reset        system clock, async active-high reset
//   cfg_table         NUM_CFG x {addr, data} config entries
//   restart           sync pulse, abort and re-run configuration
//   SDO               serial data from sensor
//   SPC, CS, SDI      SPI clock (idle high), chip select (low), data out
//   sample            burst bytes, byte k at [8k+7:8k]
//   sample_valid      one-cycle strobe on sample update
//   sample_count      completed bursts (wraps)
//   cfg_done          all config frames written
module imu_burst_sampler #(
    parameter int         CLK_DIV       = 2,
    parameter int         NUM_CFG       = 4,
    parameter int         BURST_BYTES   = 12,
    parameter logic [7:0] READ_ADDR     = 8'h22,
    parameter int         BOOT_CYCLES   = 700_000,
    parameter int         CFG_GAP       = 1000,
    parameter int         PERIOD_CYCLES = 4_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [16*NUM_CFG-1:0]      cfg_table,
    input  logic                       restart,
    input  logic                       SDO,
    output logic                       SPC,
    output logic                       CS,
    output logic                       SDI,
    output logic [8*BURST_BYTES-1:0]   sample,
    output logic                       sample_valid,
    output logic [15:0]                sample_count,
    output logic                       cfg_done
);
    localparam int W    = 8 * BURST_BYTES;
    localparam int DIV  = (CLK_DIV < 1) ? 1 : CLK_DIV;
    localparam int GAP  = (CFG_GAP < 1) ? 1 : CFG_GAP;
    localparam int BOOT = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int PER  = (PERIOD_CYCLES < 1) ? 1 : PERIOD_CYCLES;
    localparam int IW   = $clog2(NUM_CFG + 1);
    // Half-phase index of the last high phase: 0 is setup,
    // 2i+1 / 2i+2 are the low / high phases of bit i.
    localparam logic [15:0] WLAST = 16'(2 * 16);
    localparam logic [15:0] RLAST = 16'(2 * (8 + W));
    // Leaving half 2i+1 enters the high phase of bit i; data from bit 8.
    localparam logic [15:0] RX_FIRST = 16'd17;

    typedef enum logic [2:0] {
        S_BOOT, S_CFG_WR, S_CFG_GAP, S_WAIT, S_READ, S_DONE
    } state_t;

    state_t          st_q;
    logic [31:0]     cnt_q;
    logic [31:0]     per_q;
    logic [IW-1:0]   idx_q;
    logic            act_q;
    logic [15:0]     div_q;
    logic [15:0]     hc_q;
    logic [15:0]     tx_q;
    logic [W-1:0]    rx_q;

    logic [IW-1:0]   idx_d;
    logic [15:0]     ent;
    logic            launch_wr;
    logic            launch_rd;
    logic            per_hit;
    logic [W-1:0]    burst;

    always_comb begin
        per_hit   = (per_q >= 32'(PER - 1));
        launch_wr = 1'b0;
        launch_rd = 1'b0;
        idx_d     = idx_q;
        case (st_q)
            S_BOOT:    launch_wr = (cnt_q == 32'(BOOT - 1));
            // Only reachable idle after restart; frame starts next cycle.
            S_CFG_WR:  launch_wr = !act_q;
            S_CFG_GAP: begin
                if (cnt_q == 32'(GAP - 1) &&
                    32'(idx_q) < 32'(NUM_CFG - 1)) begin
                    launch_wr = 1'b1;
                    idx_d     = idx_q + 1'b1;
                end
            end
            S_WAIT:    launch_rd = per_hit;
            // Overlong bursts chain straight into the next read.
            S_DONE:    launch_rd = per_hit;
            default:   ;
        endcase
        if (restart) begin
            launch_wr = 1'b0;
            launch_rd = 1'b0;
        end
        ent = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (idx_d == IW'(i)) ent = cfg_table[16*i +: 16];
        end
    end

    // Bytes arrive first-to-last in rx_q MSB downwards.
    always_comb begin
        burst = '0;
        for (int k = 0; k < BURST_BYTES; k++) begin
            burst[8*k +: 8] = rx_q[W-8-8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= S_BOOT;
            cnt_q        <= '0;
            per_q        <= '0;
            idx_q        <= '0;
            act_q        <= 1'b0;
            div_q        <= '0;
            hc_q         <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            SPC          <= 1'b1;
            CS           <= 1'b1;
            SDI          <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            cfg_done     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (per_q < 32'(PER - 1)) per_q <= per_q + 1;
            if (st_q == S_DONE && !restart) begin
                sample       <= burst;
                sample_valid <= 1'b1;
                sample_count <= sample_count + 1'b1;
            end
            if (restart) begin
                st_q     <= S_CFG_WR;
                act_q    <= 1'b0;
                idx_q    <= '0;
                cfg_done <= 1'b0;
                CS       <= 1'b1;
                SPC      <= 1'b1;
                SDI      <= 1'b0;
            end else if (launch_wr || launch_rd) begin
                act_q <= 1'b1;
                div_q <= '0;
                hc_q  <= '0;
                CS    <= 1'b0;
                SPC   <= 1'b1;
                if (launch_rd) begin
                    st_q  <= S_READ;
                    per_q <= '0;
                    tx_q  <= {1'b1, READ_ADDR[6:0], 8'h00};
                    SDI   <= 1'b1;
                end else begin
                    st_q  <= S_CFG_WR;
                    idx_q <= idx_d;
                    tx_q  <= {1'b0, ent[14:0]};
                    SDI   <= 1'b0;
                end
            end else begin
                case (st_q)
                    S_BOOT: cnt_q <= cnt_q + 1;
                    S_CFG_GAP: begin
                        if (cnt_q == 32'(GAP - 1)) begin
                            cfg_done <= 1'b1;
                            st_q     <= S_WAIT;
                            per_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1;
                        end
                    end
                    S_DONE: st_q <= S_WAIT;
                    S_CFG_WR, S_READ: begin
                        if (div_q != 16'(DIV - 1)) begin
                            div_q <= div_q + 1'b1;
                        end else begin
                            div_q <= '0;
                            if (hc_q == ((st_q == S_READ) ? RLAST : WLAST)) begin
                                CS    <= 1'b1;
                                SPC   <= 1'b1;
                                SDI   <= 1'b0;
                                act_q <= 1'b0;
                                if (st_q == S_READ) begin
                                    st_q <= S_DONE;
                                end else begin
                                    st_q  <= S_CFG_GAP;
                                    cnt_q <= '0;
                                end
                            end else begin
                                hc_q <= hc_q + 1'b1;
                                if (!hc_q[0]) begin
                                    SPC <= 1'b0;
                                    if (hc_q != '0) begin
                                        SDI  <= tx_q[14];
                                        tx_q <= {tx_q[14:0], 1'b0};
                                    end
                                end else begin
                                    SPC <= 1'b1;
                                    if (st_q == S_READ && hc_q >= RX_FIRST)
                                        rx_q <= {rx_q[W-2:0], SDO};
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/imu_burst_sampler.md
# imu_burst_sampler

Parametrised IMU front end: owns the 4-wire SPI bus to the accelerometer/gyro, waits out sensor boot time, writes a run-time configuration table, then issues a fixed-rate burst read of BURST_BYTES consecutive registers with address auto-increment. Each completed burst is presented as one flat sample word with a one-cycle valid strobe and a sample counter. A restart input re-runs configuration without a full reset. Sits between the board-level SPI pins and the motion-processing logic.

## Interface
- CLK_DIV, 2: clk cycles per SPC half-period (>=1)
- NUM_CFG, 4: config table entries (>=1)
- BURST_BYTES, 12: bytes per burst read (>=1)
- READ_ADDR, 8'h22: first register of burst (bit 7 ignored)
- BOOT_CYCLES, 700_000: cycles from reset release before first config write
- CFG_GAP, 1000: idle cycles after each config write frame
- PERIOD_CYCLES, 4_000_000: cycles between starts of consecutive burst reads
- clk  in  1  system clock
- reset  in  1  one clock; reset is asynchronous and active-high
- cfg_table  in  16*NUM_CFG  entry i = bits [16i+15:16i] = {addr[7:0], data[7:0]}; sampled when its frame starts
- restart  in  1  pulse: abort and re-run configuration
- SDO  in  1  sensor serial data out
- SPC  out  1  SPI clock, idles high (mode 3)
- CS  out  1  chip select, active low
- SDI  out  1  sensor serial data in
- sample  out  8*BURST_BYTES  byte k received at [8k+7:8k]
- sample_valid  out  1  one-cycle pulse when sample updates
- sample_count  out  16  completed bursts, wraps 16'hFFFF -> 0
- cfg_done  out  1  high once all config frames written

## Operation
- Reset values: SPC=1, CS=1, SDI=0, sample=0, sample_valid=0, sample_count=0, cfg_done=0; state BOOT.
- States: BOOT -> CFG_WR -> CFG_GAP -> (CFG_WR next entry | WAIT) -> READ -> DONE -> WAIT.
- BOOT: count BOOT_CYCLES, then CFG_WR with index 0.
- CFG_WR: 16-bit frame {0, addr[6:0], data}, entry = cfg_table[index]; on frame end -> CFG_GAP.
- CFG_GAP: CFG_GAP idle cycles (CS high); then index+1 if index<NUM_CFG-1, else cfg_done<=1 and -> WAIT.
- WAIT: period counter runs; when it reaches PERIOD_CYCLES-1 (or already past) -> READ. Counter clears on READ entry; first entry to WAIT starts it at 0.
- READ: frame {1, READ_ADDR[6:0]} then 8*BURST_BYTES bits shifted in MSB-first per byte; -> DONE at frame end.
- DONE (one cycle): sample<=assembled burst, sample_valid=1, sample_count+=1; -> WAIT.
- Burst longer than period: next READ starts immediately after DONE (no overlap, no skipped strobe).
- restart (any state, sync): CS=1, SPC=1 next cycle, partial frame discarded, cfg_done<=0, index<=0, -> CFG_WR (no BOOT wait). sample/sample_count retained. restart held high keeps block in re-entry.
- Async reset mid-frame: pins return to idle immediately, no partial sample published.

## Timing
- Frame of N bits (N=16 write, 8+8*BURST_BYTES read): CS falls with SPC=1 and SDI=bit 0; CLK_DIV cycles setup; per bit SPC low CLK_DIV cycles then high CLK_DIV cycles; SDI changes only on SPC falling edge (bit i>0 driven at its low phase start); SDO sampled on clk edge where SPC rises; CS rises on cycle after last high phase. CS low = (2N+1)*CLK_DIV cycles.
- sample_valid asserts the cycle after CS rises at end of READ; sample stable until next DONE.
- Between frames CS high >= 1 cycle (CFG_GAP >= 1 enforced by design).
- SDI=0 whenever CS=1.

## Test plan
- CLK_DIV=2, NUM_CFG=2, BOOT_CYCLES=10, CFG_GAP=4, cfg_table={16'h1160,16'h10A0}: first CS fall at cycle 10 after reset release; SDI bits 0x10,0xA0 then 0x11,0x60; each CS low 66 cycles; cfg_done rises after second gap.
- BURST_BYTES=2, READ_ADDR=8'h22, SDO model returns 0x34,0x12: SDI sends 0xA2, sample=16'h1234, sample_valid one cycle, sample_count=1.
- PERIOD_CYCLES=200: successive CS falls of READ frames exactly 200 cycles apart over 5 bursts; sample_count 1..5.
- PERIOD_CYCLES=20 with BURST_BYTES=2 (frame 98 cycles): READ starts the cycle after DONE, every burst strobes once.
- restart asserted mid-READ bit 5: CS=1 next cycle, no sample_valid, next frame is cfg entry 0 with no boot delay, cfg_done 0 until rewritten.
- Async reset asserted mid-CFG_WR between clock edges: CS=1, SPC=1, SDI=0 immediately; sample_count=0; BOOT count restarts after release.
